// File: rtl/avm_copy_pkg.sv
// Shared definitions for the Avalon-MM block copy master.
package avm_copy_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Sliced down to DATA_W/8 by the user.
    localparam logic [127:0] BE_ALL_ONES = '1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/avm_copy_master.sv
// Avalon-MM master copying a block of words read-then-write, one word at a time,
// accumulating a wrapping 32-bit checksum of the words read.
module avm_copy_master
    import avm_copy_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W-1:0]   length,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   checksum,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);

    localparam int BE_W  = DATA_W / 8;
    localparam int LAT_W = $clog2(RD_LAT_MAX + 1);

    state_t              state;
    logic [ADDR_W-1:0]   src_ptr;
    logic [ADDR_W-1:0]   dst_ptr;
    logic [ADDR_W-1:0]   remaining;
    logic [LAT_W-1:0]    lat_cnt;
    logic [DATA_W-1:0]   data_buf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            data_buf  <= '0;
            checksum  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= length;
                        checksum  <= '0;
                        busy      <= 1'b1;
                        state     <= (length == '0) ? S_DONE : S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (!avm_waitrequest) begin
                        lat_cnt <= LAT_W'(RD_LATENCY);
                        state   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // Last count is the cycle the slave presents readdata.
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (lat_cnt == LAT_W'(1)) begin
                        data_buf <= avm_readdata;
                        checksum <= checksum + avm_readdata;
                        state    <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (!avm_waitrequest) begin
                        src_ptr   <= src_ptr + ADDR_W'(1);
                        dst_ptr   <= dst_ptr + ADDR_W'(1);
                        remaining <= remaining - ADDR_W'(1);
                        state     <= (remaining == ADDR_W'(1)) ? S_DONE : S_RD_REQ;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus strobes decode straight from state so a reset drops them immediately.
    assign avm_read       = (state == S_RD_REQ);
    assign avm_write      = (state == S_WR_REQ);
    assign avm_chipselect = avm_read | avm_write;
    assign avm_byteenable = avm_chipselect ? BE_ALL_ONES[BE_W-1:0] : '0;
    assign avm_address    = avm_read  ? src_ptr :
                            avm_write ? dst_ptr : '0;
    assign avm_writedata  = data_buf;

endmodule

// File: tb/tb_avm_copy_master.sv
// Bench for avm_copy_master: two instances (read latency 1 and 3) on a simple
// memory model with programmable waitrequest stalls; table of copy jobs.
module tb_avm_copy_master;

    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         start_v = '0;
    logic [1:0][AW-1:0] src_v = '0, dst_v = '0, len_v = '0;
    logic [1:0]         busy_v, done_v, cs_v, rd_v, wr_v, wq_v;
    logic [1:0][3:0]    be_v;
    logic [1:0][AW-1:0] addr_v;
    logic [1:0][DW-1:0] wdata_v, rdata_v, csum_v;

    logic [DW-1:0] mem [2][65536];
    int            stall_n [2];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;
    acc_t exp_q[$];

    typedef struct {
        int            g;
        logic [AW-1:0] s;
        logic [AW-1:0] d;
        logic [AW-1:0] n;
        int            stall;
        int            cyc;
        logic [DW-1:0] cs;
        int            abort_at;
    } job_t;

    logic [DW-1:0] last_cs [2];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int RL = (g == 0) ? 1 : 3;
        logic [DW-1:0] pd [RL];
        logic          pv [RL];
        int            wcnt = 0;

        avm_copy_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL)) dut (
            .clk             (clk),
            .reset_n         (reset_n),
            .start           (start_v[g]),
            .src_addr        (src_v[g]),
            .dst_addr        (dst_v[g]),
            .length          (len_v[g]),
            .busy            (busy_v[g]),
            .done            (done_v[g]),
            .checksum        (csum_v[g]),
            .avm_address     (addr_v[g]),
            .avm_chipselect  (cs_v[g]),
            .avm_read        (rd_v[g]),
            .avm_write       (wr_v[g]),
            .avm_byteenable  (be_v[g]),
            .avm_writedata   (wdata_v[g]),
            .avm_readdata    (rdata_v[g]),
            .avm_waitrequest (wq_v[g])
        );

        assign wq_v[g]    = cs_v[g] && (wcnt < stall_n[g]);
        assign rdata_v[g] = pv[RL-1] ? pd[RL-1] : 32'hDEAD_BEEF;

        // Read pipeline: data appears exactly RL cycles after the accepting cycle.
        always @(posedge clk) begin
            wcnt  <= (cs_v[g] && wq_v[g]) ? wcnt + 1 : 0;
            pv[0] <= cs_v[g] && rd_v[g] && !wq_v[g];
            pd[0] <= mem[g][addr_v[g]];
            for (int k = 1; k < RL; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_job(input job_t j);
        logic [DW-1:0] ov [logic [AW-1:0]];
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] x;
        logic [AW+1+1+DW-1:0] saved;
        acc_t e;
        int g, cyc, acc, cs_cyc, wr_done;
        bit stalled, seen, any_done;

        g = j.g;
        saved = '0;
        chk("csum_hold", csum_v[g], last_cs[g]);
        stall_n[g] = j.stall;
        exp_q.delete();
        // Sequential reference copy, so overlapping ranges see earlier writes.
        for (int i = 0; i < int'(j.n); i++) begin
            ra = j.s + AW'(i);
            wa = j.d + AW'(i);
            x  = ov.exists(ra) ? ov[ra] : mem[g][ra];
            ov[wa] = x;
            exp_q.push_back('{w: 1'b0, a: ra, d: '0});
            exp_q.push_back('{w: 1'b1, a: wa, d: x});
        end

        @(negedge clk);
        src_v[g] = j.s; dst_v[g] = j.d; len_v[g] = j.n; start_v[g] = 1'b1;
        @(posedge clk); #1;
        start_v[g] = 1'b0;
        cyc = 1; acc = 0; cs_cyc = 0; wr_done = 0; stalled = 0; seen = 0;
        chk("busy_rise", busy_v[g], 1);

        while (cyc < 400) begin
            chk("byteenable", be_v[g], cs_v[g] ? 4'hF : 4'h0);
            if (cs_v[g]) begin
                cs_cyc++;
                chk("rd_wr_excl", rd_v[g] & wr_v[g], 0);
                if (stalled)
                    chk("stall_hold", {addr_v[g], rd_v[g], wr_v[g], wdata_v[g]}, saved);
                if (wr_v[g] && j.abort_at == wr_done) begin
                    reset_n = 1'b0;
                    #1;
                    chk("abort_strobes", {cs_v[g], rd_v[g], wr_v[g], busy_v[g], done_v[g]}, 0);
                    exp_q.delete();
                    last_cs[0] = '0; last_cs[1] = '0;
                    repeat (2) @(negedge clk);
                    reset_n = 1'b1;
                    any_done = 0;
                    repeat (6) begin
                        @(posedge clk); #1;
                        any_done |= done_v[g];
                    end
                    chk("abort_no_done", any_done, 0);
                    chk("abort_idle", {busy_v[g], cs_v[g]}, 0);
                    return;
                end
                if (!wq_v[g]) begin
                    acc++;
                    stalled = 0;
                    if (exp_q.size() == 0) begin
                        chk("sb_extra_access", acc, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_kind", wr_v[g], e.w);
                        chk("sb_addr", addr_v[g], e.a);
                        if (e.w) chk("sb_data", wdata_v[g], e.d);
                    end
                    if (wr_v[g]) begin
                        mem[g][addr_v[g]] = wdata_v[g];
                        wr_done++;
                    end
                end else begin
                    stalled = 1;
                    saved = {addr_v[g], rd_v[g], wr_v[g], wdata_v[g]};
                end
            end
            if (done_v[g]) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end

        chk("done_seen", seen, 1);
        chk("done_latency", cyc, j.cyc);
        chk("busy_at_done", busy_v[g], 0);
        chk("checksum", csum_v[g], j.cs);
        chk("accepts", acc, 2 * int'(j.n));
        chk("cs_cycles", cs_cyc, 2 * int'(j.n) * (j.stall + 1));
        chk("sb_left", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("done_width", done_v[g], 0);
        chk("csum_after", csum_v[g], j.cs);
        last_cs[g] = j.cs;
    endtask

    job_t jobs [8];

    initial begin
        stall_n[0] = 0; stall_n[1] = 0;
        last_cs[0] = '0; last_cs[1] = '0;
        for (int i = 0; i < 8; i++) mem[0][16'h0010 + AW'(i)] = 32'h1111_1111 * (i + 1);
        mem[0][16'hFFFE] = 32'h1000_0001;
        mem[0][16'hFFFF] = 32'h2000_0002;
        mem[0][16'h0000] = 32'h3000_0003;
        mem[1][16'h0020] = 32'hFFFF_FFFF;
        mem[1][16'h0021] = 32'h0000_0002;
        for (int i = 0; i < 5; i++) mem[1][16'h0040 + AW'(i)] = 32'h0101_0101 * (i + 1);

        jobs[0] = '{g: 0, s: 16'h0010, d: 16'h0100, n: 16'd4, stall: 0, cyc: 14, cs: 32'hAAAA_AAAA, abort_at: -1};
        jobs[1] = '{g: 0, s: 16'h0010, d: 16'h0500, n: 16'd0, stall: 0, cyc: 2,  cs: 32'h0000_0000, abort_at: -1};
        jobs[2] = '{g: 0, s: 16'h0010, d: 16'h0200, n: 16'd4, stall: 3, cyc: 38, cs: 32'hAAAA_AAAA, abort_at: -1};
        jobs[3] = '{g: 0, s: 16'hFFFE, d: 16'h0000, n: 16'd3, stall: 0, cyc: 11, cs: 32'h4000_0004, abort_at: -1};
        jobs[4] = '{g: 1, s: 16'h0020, d: 16'h0030, n: 16'd2, stall: 0, cyc: 12, cs: 32'h0000_0001, abort_at: -1};
        jobs[5] = '{g: 1, s: 16'h0040, d: 16'h0080, n: 16'd5, stall: 1, cyc: 37, cs: 32'h0F0F_0F0F, abort_at: -1};
        jobs[6] = '{g: 0, s: 16'h0010, d: 16'h0300, n: 16'd8, stall: 0, cyc: 0,  cs: 32'h0,         abort_at: 1};
        jobs[7] = '{g: 0, s: 16'h0010, d: 16'h0400, n: 16'd4, stall: 0, cyc: 14, cs: 32'hAAAA_AAAA, abort_at: -1};

        #1;
        for (int g = 0; g < 2; g++)
            chk("reset_state", {busy_v[g], done_v[g], cs_v[g], rd_v[g], wr_v[g], be_v[g],
                                addr_v[g], wdata_v[g], csum_v[g]}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_job(jobs[i]);

        // Start pulse while busy must be ignored: second job never queues.
        @(negedge clk);
        src_v[0] = 16'h0010; dst_v[0] = 16'h0600; len_v[0] = 16'd1; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1; len_v[0] = 16'd2;
        @(negedge clk);
        start_v[0] = 1'b0;
        begin
            int dn = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (done_v[0]) dn++;
            end
            chk("start_ignored_busy", dn, 1);
            chk("start_ignored_csum", csum_v[0], 32'h1111_1111);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/avm_copy_master.md
Name: avm_copy_master

Overview:
- Avalon-MM master (initiator) that copies a block of 32-bit words from one word address range to another.
- Sits on the system fabric opposite the on-chip data memory slave and drives its address, chipselect, write, byteenable and writedata.
- Started by a one-cycle command strobe from the CPU-side control logic; reports busy, a done pulse and a running 32-bit checksum of the words copied.

Parameters:
- ADDR_W, 16, word address width; matches the memory slave's address port.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- RD_LATENCY, 1, fixed cycles from an accepted read to valid readdata; legal range 1..4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address; latched on accepted start
- dst_addr  in  ADDR_W  first destination word address; latched on accepted start
- length  in  ADDR_W  number of words to copy; 0 means no transfer
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle pulse at completion
- checksum  out  DATA_W  modulo-2^32 sum of the words read in the current or last job
- avm_address  out  ADDR_W  word address
- avm_chipselect  out  1  request valid
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_byteenable  out  DATA_W/8  all ones whenever chipselect is high, else 0
- avm_writedata  out  DATA_W  write data
- avm_readdata  in  DATA_W  read data
- avm_waitrequest  in  1  slave stall; tie 0 for the memory slave

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; busy, done, avm_chipselect, avm_read, avm_write and avm_byteenable = 0; avm_address, avm_writedata and checksum = 0; internal pointers, counters and data buffer cleared.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - On start: latch src_addr, dst_addr and length; clear checksum.
  - length == 0 -> DONE; otherwise -> RD_REQ.
  - start outside IDLE is ignored; no queuing.
- RD_REQ:
  - Drive chipselect=1, read=1, address=src_ptr.
  - Hold all outputs stable while waitrequest=1.
  - The request is accepted in the first cycle with waitrequest=0; load lat_cnt=RD_LATENCY and go to RD_WAIT.
- RD_WAIT:
  - chipselect, read and write = 0.
  - Decrement lat_cnt each cycle. readdata is valid exactly RD_LATENCY cycles after the accepting cycle.
  - In that cycle: capture readdata into buf, set checksum += readdata (wraps modulo 2^32), go to WR_REQ.
- WR_REQ:
  - Drive chipselect=1, write=1, address=dst_ptr, writedata=buf.
  - Hold while waitrequest=1.
  - On acceptance: src_ptr++ and dst_ptr++ (wrap modulo 2^ADDR_W, no error), remaining--.
  - remaining==0 after the decrement -> DONE; otherwise -> RD_REQ.
- DONE: done=1 for exactly one cycle, busy=0; -> IDLE.
- Throughput with waitrequest=0: one word per 2+RD_LATENCY cycles. Job latency from start to done pulse = length*(2+RD_LATENCY)+2 cycles.
- read and write are never asserted together.
- Overlapping src and dst ranges are copied strictly in ascending address order. Forward-overlap hazards are the software's responsibility.
- checksum holds its value after done until the next accepted start.
- Reset asserted mid-job aborts the job immediately. Words already written stay written; no done pulse is generated.

Decomposition:
- Shared package avm_copy_pkg holds:
  - state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE);
  - the byteenable all-ones constant;
  - the RD_LATENCY legal-range constants.
- Single module; the FSM and datapath are too small to justify a sub-module. Optional elaboration-time assertion on RD_LATENCY range.

Test Plan:
- Basic copy: memory model with latency 1, words 0x11111111..0x44444444 at 0x0010..0x0013; start src=0x0010, dst=0x0100, len=4 -> dst holds the same four words; done pulse exactly 14 cycles after start; checksum=0xAAAAAAAA.
- Zero length: start len=0 -> no chipselect ever asserted; done pulses 2 cycles after start; checksum=0.
- Waitrequest stall: slave holds waitrequest high for 3 cycles on each request -> address, read/write and writedata stay stable while stalled; data is correct; done is delayed by 6 cycles per word.
- Address wrap: src=0xFFFE, dst=0x0000, len=3 -> reads 0xFFFE, 0xFFFF, 0x0000; writes 0x0000, 0x0001, 0x0002. Because the third read of 0x0000 occurs after the write of 0x0000, the word copied to 0x0002 is the old src[0xFFFE] value.
- Checksum overflow and latency: RD_LATENCY=3, source words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001; 5 cycles per word.
- Reset mid-job: assert reset_n=0 during the WR_REQ of word 2 of 8 -> all strobes go low in the same cycle; busy=0; no done pulse; a new start after reset runs cleanly.
